bus_resp_router: RTL and testbench

//  Return-path companion to the address decoder on the 1-to-N bus. Forwards master requests to the

---
 rtl/bus_resp_router_pkg.sv | 13 +
 rtl/bus_resp_router_if.sv | 27 ++
 rtl/bus_resp_router_tag_fifo.sv | 37 +++
 rtl/bus_resp_router.sv | 48 ++++
 tb/tb_bus_resp_router.sv | 150 +++++++++++++++
 5 files changed

// File: rtl/bus_resp_router_pkg.sv
// bus_resp_router_pkg: shared tag type, sizing helpers and defaults for the response router.
package bus_resp_router_pkg;
   localparam int MAX_SLAVES = 16;
   localparam int IDX_W = $clog2(MAX_SLAVES);
   localparam logic [31:0] ERR_DATA_DEF = 32'hDEAD_BEEF;
   typedef struct packed {
      logic err;
      logic [IDX_W-1:0] idx;
   } rsp_tag_t;
   function automatic int tag_w(input int n_slaves);
      return $clog2(n_slaves) + 1;
   endfunction
endpackage

// File: rtl/bus_resp_router_if.sv
// bus_resp_router_if: request/response bundle between master, decoder, router and slaves.
interface bus_resp_router_if #(
   parameter int N_SLAVES = 4,
   parameter int DATA_W = 32
);
   logic m_req_valid;
   logic m_req_ready;
   logic [N_SLAVES-1:0] dec_sel;
   logic dec_err;
   logic [N_SLAVES-1:0] s_req_valid;
   logic [N_SLAVES-1:0] s_req_ready;
   logic [N_SLAVES-1:0] s_rsp_valid;
   logic [N_SLAVES-1:0] s_rsp_ready;
   logic [N_SLAVES*DATA_W-1:0] s_rsp_data;
   logic m_rsp_valid;
   logic m_rsp_ready;
   logic [DATA_W-1:0] m_rsp_data;
   logic m_rsp_err;
   modport slave (
      input m_req_valid, dec_sel, dec_err, s_req_ready, s_rsp_valid, s_rsp_data, m_rsp_ready,
      output m_req_ready, s_req_valid, s_rsp_ready, m_rsp_valid, m_rsp_data, m_rsp_err
   );
   modport master (
      output m_req_valid, dec_sel, dec_err, s_req_ready, s_rsp_valid, s_rsp_data, m_rsp_ready,
      input m_req_ready, s_req_valid, s_rsp_ready, m_rsp_valid, m_rsp_data, m_rsp_err
   );
endinterface

// File: rtl/bus_resp_router_tag_fifo.sv
// bus_resp_router_tag_fifo: in-order tag FIFO; head is visible combinationally on dout.
module bus_resp_router_tag_fifo #(
   parameter int DEPTH = 4,
   parameter int WIDTH = 5
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic push,
   input  logic pop,
   input  logic [WIDTH-1:0] din,
   output logic [WIDTH-1:0] dout,
   output logic full,
   output logic empty,
   output logic [$clog2(DEPTH):0] count
);
   localparam int AW = $clog2(DEPTH);
   logic [WIDTH-1:0] mem [DEPTH];
   logic [AW-1:0] wp, rp;
   logic do_push, do_pop;
   assign full = count == (AW+1)'(DEPTH);
   assign empty = count == '0;
   assign do_push = push && !full;
   assign do_pop = pop && !empty;
   assign dout = mem[rp];
   always_ff @(posedge clk_i)
      if (do_push) mem[wp] <= din;
   always_ff @(posedge clk_i or posedge rst_i)
      if (rst_i) begin
         wp <= '0;
         rp <= '0;
         count <= '0;
      end else begin
         wp <= wp + AW'(do_push);
         rp <= rp + AW'(do_pop);
         count <= count + (AW+1)'(do_push) - (AW+1)'(do_pop);
      end
endmodule

// File: rtl/bus_resp_router.sv
// bus_resp_router: fans requests out to the decoded slave and returns responses in issue order.
module bus_resp_router
   import bus_resp_router_pkg::*;
#(
   parameter int N_SLAVES = 4,
   parameter int DATA_W = 32,
   parameter int MAX_OUT = 4,
   parameter logic [DATA_W-1:0] ERR_DATA = DATA_W'(ERR_DATA_DEF)
) (
   input  logic clk_i,
   input  logic rst_i,
   bus_resp_router_if.slave bus,
   output logic [$clog2(MAX_OUT):0] outstanding_o
);
   localparam int SW = $clog2(N_SLAVES);
   logic [SW-1:0] idx, hidx;
   logic err, full, empty, push, pop;
   rsp_tag_t tag_in, head;
   always_comb begin
      idx = '0;
      for (int i = 0; i < N_SLAVES; i++) idx = bus.dec_sel[i] ? SW'(i) : idx;
   end
   assign err = bus.dec_err || !$onehot(bus.dec_sel);
   // rst_i gates every handshake so they drop the moment reset is asserted
   assign bus.s_req_valid = (!rst_i && bus.m_req_valid && !full && !err) ? bus.dec_sel : '0;
   assign bus.m_req_ready = !rst_i && !full && (err || bus.s_req_ready[idx]);
   assign push = bus.m_req_valid && bus.m_req_ready;
   assign tag_in = '{err: err, idx: IDX_W'(idx)};
   assign hidx = SW'(head.idx);
   assign bus.m_rsp_valid = !rst_i && !empty && (head.err || bus.s_rsp_valid[hidx]);
   assign bus.m_rsp_err = bus.m_rsp_valid && head.err;
   assign bus.m_rsp_data = !bus.m_rsp_valid ? '0 :
      head.err ? ERR_DATA : bus.s_rsp_data[int'(hidx)*DATA_W +: DATA_W];
   assign bus.s_rsp_ready = (!rst_i && !empty && !head.err && bus.m_rsp_ready) ?
      N_SLAVES'(1) << hidx : '0;
   assign pop = bus.m_rsp_valid && bus.m_rsp_ready;
   bus_resp_router_tag_fifo #(.DEPTH(MAX_OUT), .WIDTH($bits(rsp_tag_t))) u_fifo (
      .clk_i(clk_i),
      .rst_i(rst_i),
      .push(push),
      .pop(pop),
      .din(tag_in),
      .dout(head),
      .full(full),
      .empty(empty),
      .count(outstanding_o)
   );
endmodule

// File: tb/tb_bus_resp_router.sv
// tb_bus_resp_router: directed steps with an in-order response scoreboard.
module tb_bus_resp_router;
   localparam logic [31:0] ERR = 32'hDEAD_BEEF;
   logic clk = 0;
   logic rst = 1;
   logic [2:0] outstanding;
   logic [32:0] sb[$];
   logic [32:0] exp_rsp;
   logic [31:0] tbl [4] = '{32'hA0A0_0000, 32'hB1B1_1111, 32'h0000_1234, 32'hC3C3_3333};
   int n_chk = 0;
   int n_fail = 0;
   bus_resp_router_if #(.N_SLAVES(4), .DATA_W(32)) bif ();
   bus_resp_router dut (.clk_i(clk), .rst_i(rst), .bus(bif), .outstanding_o(outstanding));
   always #5 clk = ~clk;
   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_chk++;
      assert (obs === exp) else begin
         n_fail++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask
   function automatic int enc(input logic [3:0] s);
      for (int i = 0; i < 4; i++) if (s[i]) return i;
      return 0;
   endfunction
   task automatic issue(input logic [3:0] sel, input logic e, input logic acc);
      logic bad;
      bad = e || !(sel == 4'b0001 || sel == 4'b0010 || sel == 4'b0100 || sel == 4'b1000);
      @(negedge clk);
      bif.m_req_valid = 1;
      bif.dec_sel = sel;
      bif.dec_err = e;
      #1;
      chk("s_req_valid", bif.s_req_valid, (acc && !bad) ? sel : 4'b0);
      chk("m_req_ready", bif.m_req_ready, acc);
      if (acc) sb.push_back(bad ? {1'b1, ERR} : {1'b0, tbl[enc(sel)]});
      @(posedge clk);
      #1;
      bif.m_req_valid = 0;
      bif.dec_sel = 0;
      bif.dec_err = 0;
   endtask
   task automatic respond(input logic [3:0] sv, input logic [3:0] exp_rdy, input logic exp_v);
      @(negedge clk);
      bif.s_rsp_valid = sv;
      bif.m_rsp_ready = 1;
      #1;
      chk("s_rsp_ready", bif.s_rsp_ready, exp_rdy);
      chk("m_rsp_valid", bif.m_rsp_valid, exp_v);
      if (bif.m_rsp_valid) begin
         exp_rsp = sb.size() > 0 ? sb.pop_front() : 33'h1_FFFF_FFFF;
         chk("m_rsp_err", bif.m_rsp_err, exp_rsp[32]);
         chk("m_rsp_data", bif.m_rsp_data, exp_rsp[31:0]);
      end
      @(posedge clk);
      #1;
      bif.s_rsp_valid = 0;
      bif.m_rsp_ready = 0;
   endtask
   initial begin
      bif.m_req_valid = 1;
      bif.dec_sel = 4'b0001;
      bif.dec_err = 0;
      bif.s_req_ready = 4'b1111;
      bif.s_rsp_valid = 0;
      bif.m_rsp_ready = 1;
      bif.s_rsp_data = {tbl[3], tbl[2], tbl[1], tbl[0]};
      repeat (2) @(negedge clk);
      chk("rst s_req_valid", bif.s_req_valid, 0);
      chk("rst m_req_ready", bif.m_req_ready, 0);
      chk("rst m_rsp_valid", bif.m_rsp_valid, 0);
      chk("rst s_rsp_ready", bif.s_rsp_ready, 0);
      chk("rst m_rsp_data", bif.m_rsp_data, 0);
      chk("rst m_rsp_err", bif.m_rsp_err, 0);
      chk("rst outstanding", outstanding, 0);
      bif.m_req_valid = 0;
      bif.m_rsp_ready = 0;
      rst = 0;
      @(negedge clk);
      chk("idle s_req_valid", bif.s_req_valid, 0);
      chk("idle m_rsp_valid", bif.m_rsp_valid, 0);
      chk("idle m_rsp_data", bif.m_rsp_data, 0);
      chk("idle outstanding", outstanding, 0);
      // single request to slave 2
      issue(4'b0100, 0, 1);
      chk("t2 outstanding", outstanding, 1);
      chk("t2 no rsp yet", bif.m_rsp_valid, 0);
      respond(4'b0100, 4'b0100, 1);
      chk("t2 drained", outstanding, 0);
      // decode errors: explicit flag and non-one-hot select
      issue(4'b0001, 1, 1);
      chk("t3 err latency", bif.m_rsp_valid, 1);
      respond(4'b0000, 4'b0000, 1);
      issue(4'b0110, 0, 1);
      respond(4'b0000, 4'b0000, 1);
      issue(4'b0000, 0, 1);
      respond(4'b0000, 4'b0000, 1);
      // ordering: slave 0 answers early but must wait for slave 1
      issue(4'b0010, 0, 1);
      issue(4'b0001, 0, 1);
      respond(4'b0001, 4'b0010, 0);
      respond(4'b0011, 4'b0010, 1);
      respond(4'b0001, 4'b0001, 1);
      chk("t4 drained", outstanding, 0);
      // fill, then pop and offer a push together
      for (int i = 0; i < 4; i++) issue(4'b0001 << i, 0, 1);
      chk("t5 full count", outstanding, 4);
      issue(4'b0100, 0, 0);
      @(negedge clk);
      bif.m_req_valid = 1;
      bif.dec_sel = 4'b1000;
      bif.s_rsp_valid = 4'b0001;
      bif.m_rsp_ready = 1;
      #1;
      chk("t5 m_req_ready", bif.m_req_ready, 0);
      chk("t5 s_req_valid", bif.s_req_valid, 0);
      chk("t5 m_rsp_valid", bif.m_rsp_valid, 1);
      exp_rsp = sb.pop_front();
      chk("t5 m_rsp_data", bif.m_rsp_data, exp_rsp[31:0]);
      @(posedge clk);
      #1;
      bif.m_req_valid = 0;
      bif.s_rsp_valid = 0;
      chk("t5 count after", outstanding, 3);
      // async reset with three outstanding
      bif.m_req_valid = 1;
      bif.dec_sel = 4'b0001;
      #1;
      chk("t6 pre m_rsp_valid", bif.m_rsp_valid, 0);
      chk("t6 pre s_rsp_ready", bif.s_rsp_ready, 4'b0010);
      rst = 1;
      #1;
      chk("t6 s_req_valid", bif.s_req_valid, 0);
      chk("t6 m_req_ready", bif.m_req_ready, 0);
      chk("t6 s_rsp_ready", bif.s_rsp_ready, 0);
      chk("t6 outstanding", outstanding, 0);
      sb.delete();
      bif.m_req_valid = 0;
      bif.m_rsp_ready = 0;
      @(negedge clk);
      rst = 0;
      issue(4'b1000, 0, 1);
      chk("t6 new outstanding", outstanding, 1);
      respond(4'b1000, 4'b1000, 1);
      chk("end outstanding", outstanding, 0);
      chk("end scoreboard", sb.size(), 0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end
endmodule
